array_host_seq: RTL and testbench

Host-side sequencer for the PE array top: the initiator end of the array's instruction/readback interface. It buffers a program of 32-bit instructions in a FIFO and issues them one at a time with a `start` pulse, waiting for the array's completion flag between instructions. After the last instruction it sweeps `PE_Addr`/`RegAddr` over every PE and a configured register window, and returns each 16-bit word on a valid/ready result stream.

---
 rtl/array_host_seq.sv | 214 +++++++++++++++++++++
 tb/tb_array_host_seq.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/array_host_seq.sv
// Host-side sequencer for the PE array: queues a program, issues it one instruction
// at a time, then sweeps every PE over a register window and streams the words out.
module array_host_seq #(
  parameter int SIZE       = 4,
  parameter int LENGTH     = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int READ_WORDS = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [LENGTH-1:0] instr_in,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic              run,
  input  logic [9:0]        rd_base,
  output logic              busy,
  output logic              error,
  output logic [LENGTH-1:0] instruction,
  output logic              start,
  input  logic              array_done,
  output logic [SIZE-1:0]   PE_Addr,
  output logic [9:0]        RegAddr,
  input  logic [15:0]       data,
  output logic [15:0]       rd_data,
  output logic [SIZE-1:0]   rd_pe,
  output logic [9:0]        rd_reg,
  output logic              rd_valid,
  input  logic              rd_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int NPE = SIZE * SIZE;
  localparam logic [SIZE-1:0] LAST_PE  = SIZE'(NPE - 1);
  localparam logic [9:0]      LAST_REG = 10'(READ_WORDS - 1);
  localparam logic [WW-1:0]   WD_LAST  = WW'(TIMEOUT - 1);
  localparam logic [CW-1:0]   FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_RD_ADDR, S_RD_CAP, S_OUT
  } state_t;

  state_t            state_q, state_d;
  logic [LENGTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [WW-1:0]     wdog_q, wdog_d;
  logic [SIZE-1:0]   pe_q, pe_d;
  logic [9:0]        reg_q, reg_d;
  logic [9:0]        regaddr_q, regaddr_d;
  logic [9:0]        rd_base_q;
  logic              error_q;
  logic [LENGTH-1:0] instruction_q;
  logic [15:0]       rd_data_q;
  logic [SIZE-1:0]   rd_pe_q;
  logic [9:0]        rd_reg_q;
  logic              rd_valid_q;
  logic              push, pop, flush, run_acc, set_err, load_instr, cap, hs;

  assign instr_ready = (count_q != FULL_CNT);
  assign push        = instr_valid && instr_ready;
  assign busy        = (state_q != S_IDLE);
  assign start       = (state_q == S_ISSUE);
  assign error       = error_q;
  assign instruction = instruction_q;
  assign PE_Addr     = pe_q;
  assign RegAddr     = regaddr_q;
  assign rd_data     = rd_data_q;
  assign rd_pe       = rd_pe_q;
  assign rd_reg      = rd_reg_q;
  assign rd_valid    = rd_valid_q;

  always_comb begin
    state_d    = state_q;
    wdog_d     = wdog_q;
    pe_d       = pe_q;
    reg_d      = reg_q;
    regaddr_d  = regaddr_q;
    pop        = 1'b0;
    flush      = 1'b0;
    run_acc    = 1'b0;
    set_err    = 1'b0;
    load_instr = 1'b0;
    cap        = 1'b0;
    hs         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          run_acc = 1'b1;
          if (count_q != '0) begin
            state_d    = S_ISSUE;
            load_instr = 1'b1;
          end else begin
            state_d   = S_RD_ADDR;
            pe_d      = '0;
            reg_d     = '0;
            regaddr_d = rd_base;
          end
        end
      end
      S_ISSUE: begin
        pop     = 1'b1;
        wdog_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wdog_d = wdog_q + WW'(1);
        // wdog_q == 0 marks the first WAIT cycle, where array_done may be stale
        if (wdog_q != '0 && array_done) begin
          if (count_q != '0) begin
            state_d    = S_ISSUE;
            load_instr = 1'b1;
          end else begin
            state_d   = S_RD_ADDR;
            pe_d      = '0;
            reg_d     = '0;
            regaddr_d = rd_base_q;
          end
        end else if (wdog_q == WD_LAST) begin
          set_err = 1'b1;
          flush   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RD_ADDR: state_d = S_RD_CAP;
      S_RD_CAP: begin
        cap     = 1'b1;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (rd_ready) begin
          hs = 1'b1;
          if (pe_q == LAST_PE && reg_q == LAST_REG) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_RD_ADDR;
            if (reg_q == LAST_REG) begin
              reg_d = '0;
              pe_d  = pe_q + SIZE'(1);
            end else begin
              reg_d = reg_q + 10'd1;
            end
            regaddr_d = rd_base_q + reg_d;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    // A timeout discards the whole queue, including any word pushed that same cycle
    if (flush) begin
      rd_ptr_d = wr_ptr_d;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= instr_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      wdog_q        <= '0;
      pe_q          <= '0;
      reg_q         <= '0;
      regaddr_q     <= '0;
      rd_base_q     <= '0;
      error_q       <= 1'b0;
      instruction_q <= '0;
      rd_data_q     <= '0;
      rd_pe_q       <= '0;
      rd_reg_q      <= '0;
      rd_valid_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      wdog_q    <= wdog_d;
      pe_q      <= pe_d;
      reg_q     <= reg_d;
      regaddr_q <= regaddr_d;
      if (run_acc) begin
        rd_base_q <= rd_base;
        error_q   <= 1'b0;
      end else if (set_err) begin
        error_q <= 1'b1;
      end
      if (load_instr) begin
        instruction_q <= mem[rd_ptr_q];
      end
      if (cap) begin
        rd_data_q  <= data;
        rd_pe_q    <= pe_q;
        rd_reg_q   <= regaddr_q;
        rd_valid_q <= 1'b1;
      end else if (hs) begin
        rd_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_array_host_seq.sv
// Randomised bench for array_host_seq: an array model answers start/readback, and a
// cycle-level scoreboard derives every expected output from the sequencing rules.
module tb_array_host_seq;

  localparam int SIZE  = 4;
  localparam int RW    = 4;
  localparam int TO    = 1023;
  localparam int DEPTH = 16;
  localparam int NPE   = SIZE * SIZE;

  typedef enum int {M_IDLE, M_EXEC, M_READ} mstate_t;
  typedef struct {int pe; int rg;} word_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr_in = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic        run = 1'b0;
  logic [9:0]  rd_base = '0;
  logic        busy, error, start;
  logic [31:0] instruction;
  logic        arr_done = 1'b0;
  logic [SIZE-1:0] PE_Addr, rd_pe;
  logic [9:0]  RegAddr, rd_reg;
  logic [15:0] arr_data = '0;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        rd_ready = 1'b1;

  array_host_seq #(.SIZE(SIZE), .LENGTH(32), .FIFO_DEPTH(DEPTH), .READ_WORDS(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .run(run), .rd_base(rd_base), .busy(busy), .error(error),
    .instruction(instruction), .start(start), .array_done(arr_done), .PE_Addr(PE_Addr),
    .RegAddr(RegAddr), .data(arr_data), .rd_data(rd_data), .rd_pe(rd_pe), .rd_reg(rd_reg),
    .rd_valid(rd_valid), .rd_ready(rd_ready)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [15:0] fdata(input int pe, input int rg);
    int v;
    v = (pe * 4919) ^ (rg * 177) ^ 23040;
    return v[15:0];
  endfunction

  // Array model: synchronous readback RAM, done flag raised lat cycles after start
  int   lat = 4;
  int   arr_cnt = 0;
  logic start_d1 = 1'b0;
  always @(posedge clk) begin
    start_d1 <= start;
    arr_data <= fdata(int'(PE_Addr), int'(RegAddr));
    if (reset) begin
      arr_done <= 1'b0;
      arr_cnt  <= 0;
    end else begin
      if (start_d1) arr_done <= 1'b0;
      if (start) arr_cnt <= (lat >= 2) ? lat - 1 : 0;
      else if (arr_cnt != 0) begin
        arr_cnt <= arr_cnt - 1;
        if (arr_cnt == 1) arr_done <= 1'b1;
      end
    end
  end

  // Consumer: 0 always ready, 1 pattern 0,0,1, 2 random, 3 never ready
  int rdy_mode = 0;
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: rd_ready = 1'b1;
        1: begin rd_ready = (ph == 2); ph = (ph + 1) % 3; end
        2: rd_ready = 1'($urandom_range(0, 1));
        default: rd_ready = 1'b0;
      endcase
    end
  end

  // Scoreboard state
  int          cyc = 0;
  logic        rst_at_edge = 1'b0;
  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= reset;
  end

  logic [31:0] prog[$];
  word_t       rdq[$];
  logic [31:0] start_log[$];
  int          hs_log[$];
  mstate_t     m_state = M_IDLE;
  logic        m_error = 1'b0;
  logic [31:0] m_instr = '0;
  int          m_pe = 0, m_reg = 0, base = 0;
  logic        m_vld = 1'b0;
  int          exp_start_cyc = -1, exp_addr_cyc = -1, exp_valid_cyc = -1;
  int          last_start = -100000;

  task automatic build_rdq();
    rdq.delete();
    for (int p = 0; p < NPE; p++)
      for (int r = 0; r < RW; r++) begin
        word_t w;
        w.pe = p;
        w.rg = (base + r) % 1024;
        rdq.push_back(w);
      end
  endtask

  always @(negedge clk) begin
    int      sz0;
    mstate_t st0;
    logic    flush;
    if (rst_at_edge) begin
      prog.delete(); rdq.delete();
      m_state = M_IDLE; m_error = 1'b0; m_instr = '0; m_pe = 0; m_reg = 0; m_vld = 1'b0;
      exp_start_cyc = -1; exp_addr_cyc = -1; exp_valid_cyc = -1; last_start = -100000;
      chk("reset_rd_data", rd_data, 0);
      chk("reset_rd_pe", rd_pe, 0);
      chk("reset_rd_reg", rd_reg, 0);
    end
    sz0 = prog.size();
    st0 = m_state;
    chk("start", start, cyc == exp_start_cyc);
    if (start) begin
      start_log.push_back(instruction);
      last_start    = cyc;
      exp_start_cyc = -1;
      m_state       = M_EXEC;
      if (prog.size() > 0) m_instr = prog.pop_front();
      else chk("start_with_empty_fifo", 1, 0);
    end
    chk("instruction", instruction, m_instr);
    chk("instr_ready", instr_ready, sz0 < DEPTH);
    chk("busy", busy, st0 != M_IDLE);
    chk("error", error, m_error);
    if (cyc == exp_addr_cyc) begin
      m_pe = rdq[0].pe;
      m_reg = rdq[0].rg;
      exp_addr_cyc = -1;
      exp_valid_cyc = cyc + 2;
    end
    chk("PE_Addr", PE_Addr, m_pe);
    chk("RegAddr", RegAddr, m_reg);
    if (cyc == exp_valid_cyc) begin
      m_vld = 1'b1;
      exp_valid_cyc = -1;
    end
    chk("rd_valid", rd_valid, m_vld);
    if (m_vld) begin
      chk("rd_pe", rd_pe, rdq[0].pe);
      chk("rd_reg", rd_reg, rdq[0].rg);
      chk("rd_data", rd_data, fdata(rdq[0].pe, rdq[0].rg));
    end
    if (!reset) begin
      flush = 1'b0;
      if (m_vld && rd_ready) begin
        hs_log.push_back(rdq[0].rg);
        rdq.pop_front();
        m_vld = 1'b0;
        if (rdq.size() == 0) m_state = M_IDLE;
        else exp_addr_cyc = cyc + 1;
      end
      if (st0 == M_EXEC && exp_start_cyc < 0 && cyc > last_start) begin
        if (cyc >= last_start + 2 && arr_done) begin
          if (prog.size() > 0) exp_start_cyc = cyc + 1;
          else begin
            m_state = M_READ;
            build_rdq();
            exp_addr_cyc = cyc + 1;
          end
        end else if (cyc == last_start + TO) begin
          m_error = 1'b1;
          prog.delete();
          flush = 1'b1;
          m_state = M_IDLE;
        end
      end
      if (run && st0 == M_IDLE) begin
        m_error = 1'b0;
        base = int'(rd_base);
        if (sz0 > 0) begin
          exp_start_cyc = cyc + 1;
          last_start = cyc + 1;
          m_state = M_EXEC;
        end else begin
          m_state = M_READ;
          build_rdq();
          exp_addr_cyc = cyc + 1;
        end
      end
      if (instr_valid && sz0 < DEPTH && !flush) prog.push_back(instr_in);
    end
  end

  // Stimulus helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    instr_valid = 1'b1;
    instr_in    = w;
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic do_run(input int b);
    run     = 1'b1;
    rd_base = 10'(b);
    tick();
    run = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    tick();
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk("idle_within_budget", busy, 0);
  endtask

  task automatic clear_logs();
    start_log.delete();
    hs_log.delete();
  endtask

  logic [31:0] fill[16];

  initial begin
    int n, k;
    repeat (3) tick();
    reset = 1'b0;
    chk("reset_instr_ready", instr_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_error", error, 0);
    chk("reset_start", start, 0);
    chk("reset_instruction", instruction, 0);

    // Three-instruction program, array answers 4 cycles after each start
    clear_logs(); lat = 4; rdy_mode = 0;
    push(32'h11111111); push(32'h22222222); push(32'h33333333);
    do_run(0);
    wait_idle(2000);
    chk("t1_starts", start_log.size(), 3);
    if (start_log.size() == 3) begin
      chk("t1_instr0", start_log[0], 32'h11111111);
      chk("t1_instr1", start_log[1], 32'h22222222);
      chk("t1_instr2", start_log[2], 32'h33333333);
    end
    chk("t1_words", hs_log.size(), 64);

    // Backpressure 0,0,1
    clear_logs(); lat = 3; rdy_mode = 1;
    push($urandom); push($urandom);
    do_run($urandom_range(0, 1023));
    wait_idle(4000);
    chk("t2_starts", start_log.size(), 2);
    chk("t2_words", hs_log.size(), 64);

    // FIFO full, 17th word dropped, refills while popping
    clear_logs(); lat = 2; rdy_mode = 0;
    for (int i = 0; i < 16; i++) begin
      fill[i] = $urandom;
      push(fill[i]);
    end
    chk("t3_full_ready", instr_ready, 0);
    push(32'hDEADBEEF);
    chk("t3_still_full", instr_ready, 0);
    do_run(5);
    instr_valid = 1'b1;
    repeat (40) begin
      instr_in = $urandom;
      tick();
    end
    instr_valid = 1'b0;
    wait_idle(6000);
    if (start_log.size() >= 16) begin
      for (int i = 0; i < 16; i++) chk("t3_order", start_log[i], fill[i]);
    end else chk("t3_starts", start_log.size(), 16);
    chk("t3_words", hs_log.size(), 64);

    // Watchdog timeout
    clear_logs(); lat = 0;
    push(32'hCAFEF00D);
    do_run(0);
    n = 0;
    while (!error && n < 1100) begin
      tick();
      n++;
    end
    chk("t4_timeout_cycles", n, 1024);
    chk("t4_idle", busy, 0);
    chk("t4_no_readback", hs_log.size(), 0);
    lat = 3;
    do_run(100);
    chk("t4_error_cleared", error, 0);
    wait_idle(2000);
    chk("t4_single_start", start_log.size(), 1);
    chk("t4_words", hs_log.size(), 64);

    // Window wrap at 1023 -> 0, empty program
    clear_logs();
    do_run(1022);
    wait_idle(2000);
    chk("t5_starts", start_log.size(), 0);
    chk("t5_words", hs_log.size(), 64);
    if (hs_log.size() >= 5) begin
      chk("t5_reg0", hs_log[0], 1022);
      chk("t5_reg1", hs_log[1], 1023);
      chk("t5_reg2", hs_log[2], 0);
      chk("t5_reg3", hs_log[3], 1);
      chk("t5_reg4", hs_log[4], 1022);
    end

    // Reset during WAIT
    lat = 0;
    push($urandom); push($urandom);
    do_run(0);
    repeat (6) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_busy", busy, 0);
    chk("t6_start", start, 0);
    chk("t6_instruction", instruction, 0);
    clear_logs(); lat = 3;
    push(32'h0BADF00D);
    do_run(7);
    wait_idle(2000);
    chk("t6_starts", start_log.size(), 1);
    if (start_log.size() == 1) chk("t6_instr", start_log[0], 32'h0BADF00D);
    chk("t6_words", hs_log.size(), 64);

    // Reset during OUT
    rdy_mode = 3;
    do_run(0);
    n = 0;
    while (!rd_valid && n < 20) begin
      tick();
      n++;
    end
    chk("t7_reached_out", rd_valid, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t7_rd_valid", rd_valid, 0);
    chk("t7_busy", busy, 0);
    clear_logs(); rdy_mode = 0;
    do_run(3);
    wait_idle(2000);
    chk("t7_words", hs_log.size(), 64);

    // Randomised programs
    repeat (5) begin
      clear_logs();
      lat = $urandom_range(2, 7);
      rdy_mode = 2;
      k = $urandom_range(0, 4);
      for (int i = 0; i < k; i++) push($urandom);
      do_run($urandom_range(0, 1023));
      wait_idle(6000);
      chk("rand_starts", start_log.size(), k);
      chk("rand_words", hs_log.size(), 64);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
